// File: rtl/viterbi_pkg.sv
// viterbi_pkg: constraint length, default generators and encoder FSM states shared by encoder and decoder
package viterbi_pkg;
  localparam int K = 3;
  localparam logic [K-1:0] G0_DEF = 3'b111;
  localparam logic [K-1:0] G1_DEF = 3'b101;
  typedef enum logic [1:0] {RUN, TAIL1, TAIL2} enc_state_t;
endpackage

// File: rtl/conv_encoder_if.sv
// conv_encoder_if: input bit stream and encoded pair stream of the convolutional encoder
interface conv_encoder_if #(parameter int CNT_W = 16);
  logic in_valid;
  logic in_ready;
  logic in_bit;
  logic in_last;
  logic enc_valid;
  logic out_ready;
  logic [1:0] enc_pair;
  logic enc_last;
  logic [CNT_W-1:0] pair_cnt;
  modport master (
    output in_valid, in_bit, in_last, out_ready,
    input  in_ready, enc_valid, enc_pair, enc_last, pair_cnt
  );
  modport slave (
    input  in_valid, in_bit, in_last, out_ready,
    output in_ready, enc_valid, enc_pair, enc_last, pair_cnt
  );
endinterface

// File: rtl/conv_enc_core.sv
// conv_enc_core: combinational rate-1/2 pair from {d,s1,s0}
module conv_enc_core import viterbi_pkg::*; #(
  parameter logic [K-1:0] G0 = G0_DEF,
  parameter logic [K-1:0] G1 = G1_DEF
) (
  input  logic [K-1:0] i_reg,
  output logic [1:0]   o_pair
);
  assign o_pair = {^(G0 & i_reg), ^(G1 & i_reg)};
endmodule

// File: rtl/conv_encoder.sv
// conv_encoder: K=3 rate-1/2 encoder; define CONV_ENC_TAIL_EN for zero-tail termination, otherwise frames are truncated
module conv_encoder import viterbi_pkg::*; #(
  parameter logic [K-1:0] G0 = G0_DEF,
  parameter logic [K-1:0] G1 = G1_DEF,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  conv_encoder_if.slave bus
);
  enc_state_t r_state, w_state_nx;
  logic [1:0] r_sh, r_pair, w_pair;
  logic [CNT_W-1:0] r_cnt;
  logic r_valid, r_last;
  logic w_free, w_acc, w_emit, w_d, w_last, w_clr;
  conv_enc_core #(.G0(G0), .G1(G1)) u_core (.i_reg({w_d, r_sh}), .o_pair(w_pair));
  assign w_free        = !r_valid || bus.out_ready;
  assign bus.in_ready  = rst && r_state == RUN && w_free;
  assign w_acc         = bus.in_valid && bus.in_ready;
  assign bus.enc_valid = r_valid;
  assign bus.enc_pair  = r_pair;
  assign bus.enc_last  = r_last;
  assign bus.pair_cnt  = r_cnt;
  // next state and the bit fed to the encoder: data in RUN, flushing zeros in the tail states
  always_comb begin
    w_state_nx = RUN;
    w_d        = bus.in_bit;
    w_emit     = w_acc;
    w_last     = bus.in_last;
    w_clr      = bus.in_last;
`ifdef CONV_ENC_TAIL_EN
    w_d        = r_state == RUN && bus.in_bit;
    w_emit     = r_state == RUN ? w_acc : w_free;
    w_last     = r_state == TAIL2;
    w_clr      = 1'b0;
    w_state_nx = r_state == RUN ? (w_acc && bus.in_last ? TAIL1 : RUN) :
                 !w_free ? r_state : r_state == TAIL1 ? TAIL2 : RUN;
`endif
  end
  // FSM state register
  always_ff @(posedge clk)
    if (!rst) r_state <= RUN;
    else r_state <= w_state_nx;
  // output slot and shift state advance together; the slot holds while downstream stalls
  always_ff @(posedge clk)
    if (!rst) begin
      r_sh    <= 2'b00;
      r_valid <= 1'b0;
      r_pair  <= 2'b00;
      r_last  <= 1'b0;
    end else if (w_emit) begin
      r_sh    <= w_clr ? 2'b00 : {w_d, r_sh[1]};
      r_valid <= 1'b1;
      r_pair  <= w_pair;
      r_last  <= w_last;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  // per-frame pair counter, saturating, cleared when the final pair leaves
  always_ff @(posedge clk)
    if (!rst) r_cnt <= '0;
    else if (r_valid && bus.out_ready) r_cnt <= r_last ? '0 : &r_cnt ? r_cnt : r_cnt + 1'b1;
endmodule
